// File: rtl/vga_pkg.sv
// 800x600@60 Hz raster timing constants shared by the timing generator and
// the drawing stages (which only need the active area).
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster source: pixel/line counters plus registered sync and blanking
// strobes, all decoded from the next-state counters so they stay cycle-aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST        = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_BLANK_START = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_STOP   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST        = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_BLANK_START = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_STOP   = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2**CW) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > 2**CW) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          frame_start_q, frame_start_d;
  logic          h_wrap, v_wrap;

  assign h_wrap = (hcount_q == H_LAST);
  assign v_wrap = (vcount_q == V_LAST);

  // Strobes decode the next-state counters so they land on the same edge.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (en) begin
      hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end
      frame_start_d = h_wrap && v_wrap;
    end
    hblnk_d = (hcount_d >= H_BLANK_START);
    hsync_d = (hcount_d >= H_SYNC_START) && (hcount_d < H_SYNC_STOP);
    vblnk_d = (vcount_d >= V_BLANK_START);
    vsync_d = (vcount_d >= V_SYNC_START) && (vcount_d < V_SYNC_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_q <= '0;
    end else begin
      vcount_q <= vcount_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800x600 instance for line timing plus a
// scaled-down instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } out_t;

  logic        clk;
  logic        rst_n;
  logic        en;

  logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs;
  logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs;

  int vectors    = 0;
  int miscompares = 0;
  int n          = 0;
  bit last_en    = 1'b0;
  bit mon_on     = 1'b0;
  bit stats_on   = 1'b0;
  int fs_cnt     = 0;
  int rise_cnt   = 0;
  int last_rise  = 0;
  int vis_cnt    = 0;
  bit prev_vs    = 1'b0;

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(d_hcount), .vcount(d_vcount),
    .hsync(d_hsync), .vsync(d_vsync),
    .hblnk(d_hblnk), .vblnk(d_vblnk),
    .frame_start(d_fs)
  );

  // 25 x 16 raster: 400 enabled cycles per frame.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .CW(11)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(s_hcount), .vcount(s_vcount),
    .hsync(s_hsync), .vsync(s_vsync),
    .hblnk(s_hblnk), .vblnk(s_vblnk),
    .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model state: number of enabled edges since reset and whether the last edge was enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n       = 0;
      last_en = 1'b0;
    end else begin
      if (en) n++;
      last_en = en;
    end
  end

  function automatic out_t modelOut(int cnt, bit le, int ha, int hf, int hsw, int hbp,
                                    int va, int vf, int vsw, int vbp);
    int   ht;
    int   vt;
    int   h;
    int   v;
    out_t o;
    ht   = ha + hf + hsw + hbp;
    vt   = va + vf + vsw + vbp;
    h    = cnt % ht;
    v    = (cnt / ht) % vt;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hb = (h >= ha);
    o.hs = (h >= ha + hf) && (h < ha + hf + hsw);
    o.vb = (v >= va);
    o.vs = (v >= va + vf) && (v < va + vf + vsw);
    o.fs = le && (cnt > 0) && (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareOut(string name, out_t got, out_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at n=%0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
               name, n, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.fs,
               want.h, want.v, want.hs, want.vs, want.hb, want.vb, want.fs);
    end
  endtask

  function automatic out_t defOut();
    return {d_hcount, d_vcount, d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs};
  endfunction

  function automatic out_t smlOut();
    return {s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs};
  endfunction

  // Per-cycle compare of both instances, plus frame statistics for the small raster.
  always @(negedge clk) begin
    if (mon_on) begin
      compareOut("model_full", defOut(), modelOut(n, last_en, 800, 40, 128, 88, 600, 1, 4, 23));
      compareOut("model_small", smlOut(), modelOut(n, last_en, 16, 2, 4, 3, 10, 1, 2, 3));
      if (stats_on) begin
        if (s_fs) fs_cnt++;
        if (s_vsync && !prev_vs) begin
          if (rise_cnt > 0) checkOutput("vsync_period", n - last_rise, 400);
          last_rise = n;
          rise_cnt++;
        end
        if (n >= 400 && n < 800 && !s_hblnk && !s_vblnk) vis_cnt++;
      end
      prev_vs = s_vsync;
    end
  end

  task automatic applyStimulus(bit en_val, int cycles);
    en = en_val;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    checkOutput("reset_all_zero", int'(defOut()), 0);

    rst_n = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("first_edge_h", d_hcount, 1);
    checkOutput("first_edge_v", d_vcount, 0);
    checkOutput("first_edge_fs", d_fs, 0);

    // Line timing on the full-size raster.
    applyStimulus(1'b1, 798);
    checkOutput("hblnk_799", d_hblnk, 0);
    applyStimulus(1'b1, 1);
    checkOutput("hblnk_800", d_hblnk, 1);
    checkOutput("hcount_800", d_hcount, 800);
    applyStimulus(1'b1, 39);
    checkOutput("hsync_839", d_hsync, 0);
    applyStimulus(1'b1, 1);
    checkOutput("hsync_840", d_hsync, 1);
    applyStimulus(1'b1, 127);
    checkOutput("hsync_967", d_hsync, 1);
    applyStimulus(1'b1, 1);
    checkOutput("hsync_968", d_hsync, 0);
    applyStimulus(1'b1, 87);
    checkOutput("hcount_1055", d_hcount, 1055);
    checkOutput("vcount_line0", d_vcount, 0);
    applyStimulus(1'b1, 1);
    checkOutput("hcount_wrap", d_hcount, 0);
    checkOutput("vcount_step", d_vcount, 1);
    checkOutput("no_fs_line_wrap", d_fs, 0);

    // Asynchronous reset in the middle of a line / frame.
    applyStimulus(1'b1, 500);
    checkOutput("pre_reset_h", d_hcount, 500);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_full", int'(defOut()), 0);
    checkOutput("async_reset_small", int'(smlOut()), 0);
    repeat (2) @(negedge clk);
    stats_on = 1'b1;
    rst_n    = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("release_h", d_hcount, 1);
    checkOutput("release_v", d_vcount, 0);
    checkOutput("release_fs", d_fs, 0);

    // Three whole frames of the small raster.
    applyStimulus(1'b1, 1199);
    #1;
    checkOutput("frame_start_count", fs_cnt, 3);
    checkOutput("vsync_rise_count", rise_cnt, 3);
    checkOutput("visible_pixels", vis_cnt, 160);
    checkOutput("wrap_pulse", s_fs, 1);
    stats_on = 1'b0;

    // Disabling right after the pulse drops frame_start and holds the counters.
    applyStimulus(1'b0, 1);
    checkOutput("fs_forced_low", s_fs, 0);
    checkOutput("hold_h_zero", s_hcount, 0);

    // Freeze at the last pixel of the frame, then resume into the wrap.
    applyStimulus(1'b1, 399);
    checkOutput("last_pixel_h", s_hcount, 24);
    checkOutput("last_pixel_v", s_vcount, 15);
    applyStimulus(1'b0, 17);
    checkOutput("frozen_small", int'(smlOut()), int'(out_t'({11'd24, 11'd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0})));
    applyStimulus(1'b1, 1);
    checkOutput("resume_wrap", int'(smlOut()), int'(out_t'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})));
    applyStimulus(1'b1, 1);
    checkOutput("pulse_one_cycle", s_fs, 0);
    checkOutput("after_wrap_h", s_hcount, 1);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
